// File: rtl/agc_mct_sequencer.sv
// Timepulse generator and control-pulse sequencer for the service-gate module.
// Each MCT is arbitrated at TP==NTP and pulses are decoded from the next (MCT, TP) pair into registers.
module agc_mct_sequencer #(
    parameter int NTP    = 12,
    parameter int MAXINC = 3
) (
    input  logic       CLOCK,
    input  logic       rst_,
    input  logic       GOJAM,
    input  logic       SEQV,
    input  logic [1:0] SEQ,
    input  logic       INCREQ,
    input  logic       INCSGN,
    output logic [3:0] TP,
    output logic       T12_,
    output logic       SEQACK,
    output logic       INCACK,
    output logic       BUSY,
    output logic       RG_,
    output logic       WG_,
    output logic       RA_,
    output logic       WA_,
    output logic       RB_,
    output logic       WB_,
    output logic       WY_,
    output logic       RU_,
    output logic       A2X_,
    output logic       MONEX_,
    output logic       CI
);

    typedef enum logic [2:0] {
        MCT_NOOP,
        MCT_CA,
        MCT_TS,
        MCT_AD,
        MCT_PINC,
        MCT_MINC
    } mct_e;

    localparam logic [3:0] TP_LAST    = 4'(NTP);
    localparam logic [3:0] STREAK_MAX = 4'(MAXINC);

    localparam logic [10:0] G_RG    = 11'h400;
    localparam logic [10:0] G_WG    = 11'h200;
    localparam logic [10:0] G_RA    = 11'h100;
    localparam logic [10:0] G_WA    = 11'h080;
    localparam logic [10:0] G_RB    = 11'h040;
    localparam logic [10:0] G_WB    = 11'h020;
    localparam logic [10:0] G_WY    = 11'h010;
    localparam logic [10:0] G_RU    = 11'h008;
    localparam logic [10:0] G_A2X   = 11'h004;
    localparam logic [10:0] G_MONEX = 11'h002;
    localparam logic [10:0] G_CI    = 11'h001;

    mct_e        mct_q, mct_d;
    logic [3:0]  tp_q, tp_d;
    logic [3:0]  streak_q, streak_d;
    logic        seqack_q, seqack_d;
    logic        incack_q, incack_d;
    logic        t12_q, t12_d;
    logic        busy_q, busy_d;
    logic [10:0] gate_q, gate_d;

    function automatic mct_e seq_to_mct(input logic [1:0] s);
        mct_e m;
        case (s)
            2'd1:    m = MCT_CA;
            2'd2:    m = MCT_TS;
            2'd3:    m = MCT_AD;
            default: m = MCT_NOOP;
        endcase
        return m;
    endfunction

    // Active-high gate set for one timepulse of one MCT type.
    function automatic logic [10:0] pulse_decode(input mct_e m, input logic [3:0] t);
        logic [10:0] g;
        g = '0;
        case (m)
            MCT_CA: begin
                if (t == 4'd7)  g = G_RG | G_WB;
                if (t == 4'd10) g = G_RB | G_WA;
            end
            MCT_TS: begin
                if (t == 4'd5)  g = G_RA | G_WG;
            end
            MCT_AD: begin
                if (t == 4'd7)  g = G_RG | G_WB;
                if (t == 4'd8)  g = G_RB | G_WY | G_A2X;
                if (t == 4'd10) g = G_RU | G_WA;
            end
            MCT_PINC: begin
                if (t == 4'd5)  g = G_RG | G_WY | G_CI;
                if (t == 4'd7)  g = G_RU | G_WG;
            end
            MCT_MINC: begin
                if (t == 4'd5)  g = G_RG | G_WY | G_MONEX;
                if (t == 4'd7)  g = G_RU | G_WG;
            end
            default: g = '0;
        endcase
        return g;
    endfunction

    always_comb begin
        tp_d     = (tp_q == TP_LAST) ? 4'd1 : tp_q + 4'd1;
        mct_d    = mct_q;
        streak_d = streak_q;
        seqack_d = 1'b0;
        incack_d = 1'b0;

        if (GOJAM) begin
            tp_d     = 4'd1;
            mct_d    = MCT_NOOP;
            streak_d = '0;
        end else if (tp_q == TP_LAST) begin
            // Increments win unless a subsequence has waited out a full streak.
            if (INCREQ && !(SEQV && (streak_q == STREAK_MAX))) begin
                mct_d    = INCSGN ? MCT_MINC : MCT_PINC;
                incack_d = 1'b1;
                if (streak_q != STREAK_MAX) begin
                    streak_d = streak_q + 4'd1;
                end
            end else if (SEQV) begin
                mct_d    = seq_to_mct(SEQ);
                seqack_d = 1'b1;
                streak_d = '0;
            end else begin
                mct_d    = MCT_NOOP;
                streak_d = '0;
            end
        end

        t12_d  = (tp_d != TP_LAST);
        busy_d = (mct_d != MCT_NOOP);
        gate_d = pulse_decode(mct_d, tp_d);
    end

    always_ff @(posedge CLOCK or negedge rst_) begin
        if (!rst_) begin
            tp_q     <= 4'd1;
            mct_q    <= MCT_NOOP;
            streak_q <= '0;
            seqack_q <= 1'b0;
            incack_q <= 1'b0;
            t12_q    <= 1'b1;
            busy_q   <= 1'b0;
            gate_q   <= '0;
        end else begin
            tp_q     <= tp_d;
            mct_q    <= mct_d;
            streak_q <= streak_d;
            seqack_q <= seqack_d;
            incack_q <= incack_d;
            t12_q    <= t12_d;
            busy_q   <= busy_d;
            gate_q   <= gate_d;
        end
    end

    assign TP     = tp_q;
    assign T12_   = t12_q;
    assign SEQACK = seqack_q;
    assign INCACK = incack_q;
    assign BUSY   = busy_q;
    assign RG_    = ~gate_q[10];
    assign WG_    = ~gate_q[9];
    assign RA_    = ~gate_q[8];
    assign WA_    = ~gate_q[7];
    assign RB_    = ~gate_q[6];
    assign WB_    = ~gate_q[5];
    assign WY_    = ~gate_q[4];
    assign RU_    = ~gate_q[3];
    assign A2X_   = ~gate_q[2];
    assign MONEX_ = ~gate_q[1];
    assign CI     = gate_q[0];

endmodule

// File: tb/tb_agc_mct_sequencer.sv
// Bench for agc_mct_sequencer: a table-driven MCT model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_agc_mct_sequencer;

    localparam int NTP    = 12;
    localparam int MAXINC = 3;

    localparam int K_NOOP = 0, K_CA = 1, K_TS = 2, K_AD = 3, K_PINC = 4, K_MINC = 5;

    localparam logic [10:0] P_RG = 11'h400, P_WG = 11'h200, P_RA = 11'h100, P_WA = 11'h080;
    localparam logic [10:0] P_RB = 11'h040, P_WB = 11'h020, P_WY = 11'h010, P_RU = 11'h008;
    localparam logic [10:0] P_A2X = 11'h004, P_MONEX = 11'h002, P_CI = 11'h001;

    typedef struct {
        int          kind;
        int          step;
        logic [10:0] mask;
    } pulse_row_t;

    pulse_row_t pulse_rows [10] = '{
        '{K_CA,   7,  P_RG | P_WB},
        '{K_CA,   10, P_RB | P_WA},
        '{K_TS,   5,  P_RA | P_WG},
        '{K_AD,   7,  P_RG | P_WB},
        '{K_AD,   8,  P_RB | P_WY | P_A2X},
        '{K_AD,   10, P_RU | P_WA},
        '{K_PINC, 5,  P_RG | P_WY | P_CI},
        '{K_PINC, 7,  P_RU | P_WG},
        '{K_MINC, 5,  P_RG | P_WY | P_MONEX},
        '{K_MINC, 7,  P_RU | P_WG}
    };

    logic       CLOCK = 1'b0;
    logic       rst_  = 1'b1;
    logic       GOJAM = 1'b0;
    logic       SEQV  = 1'b0;
    logic [1:0] SEQ   = 2'd0;
    logic       INCREQ = 1'b0;
    logic       INCSGN = 1'b0;
    logic [3:0] TP;
    logic       T12_, SEQACK, INCACK, BUSY;
    logic       RG_, WG_, RA_, WA_, RB_, WB_, WY_, RU_, A2X_, MONEX_, CI;

    int compared   = 0;
    int mismatched = 0;
    bit checking   = 1'b0;

    agc_mct_sequencer #(.NTP(NTP), .MAXINC(MAXINC)) dut (
        .CLOCK(CLOCK), .rst_(rst_), .GOJAM(GOJAM), .SEQV(SEQV), .SEQ(SEQ),
        .INCREQ(INCREQ), .INCSGN(INCSGN), .TP(TP), .T12_(T12_),
        .SEQACK(SEQACK), .INCACK(INCACK), .BUSY(BUSY),
        .RG_(RG_), .WG_(WG_), .RA_(RA_), .WA_(WA_), .RB_(RB_), .WB_(WB_),
        .WY_(WY_), .RU_(RU_), .A2X_(A2X_), .MONEX_(MONEX_), .CI(CI)
    );

    always #5 CLOCK = ~CLOCK;

    function automatic logic [10:0] observed_gates();
        return {~RG_, ~WG_, ~RA_, ~WA_, ~RB_, ~WB_, ~WY_, ~RU_, ~A2X_, ~MONEX_, CI};
    endfunction

    function automatic logic [10:0] expected_gates(input int kind, input int step);
        logic [10:0] acc;
        acc = '0;
        foreach (pulse_rows[i])
            if (pulse_rows[i].kind == kind && pulse_rows[i].step == step)
                acc = acc | pulse_rows[i].mask;
        return acc;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit gojam, input bit seqv, input int seq,
                                 input bit increq, input bit incsgn);
        GOJAM  = gojam;
        SEQV   = seqv;
        SEQ    = 2'(seq);
        INCREQ = increq;
        INCSGN = incsgn;
    endtask

    task automatic wait_tp(input int n);
        int budget;
        budget = 0;
        do begin
            @(negedge CLOCK);
            budget++;
        end while (int'(TP) != n && budget < 40);
        if (int'(TP) != n) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL wait_tp: TP=%0d never reached %0d", TP, n);
        end
    endtask

    // Model of the MCT as plain integers: timepulse, MCT kind, streak, acks.
    int m_tp = 1, m_kind = K_NOOP, m_streak = 0;
    bit m_seqack = 0, m_incack = 0;

    always @(posedge CLOCK or negedge rst_) begin
        if (!rst_) begin
            m_tp = 1; m_kind = K_NOOP; m_streak = 0; m_seqack = 0; m_incack = 0;
        end else begin
            m_seqack = 0;
            m_incack = 0;
            if (GOJAM) begin
                m_tp = 1; m_kind = K_NOOP; m_streak = 0;
            end else if (m_tp == NTP) begin
                m_tp = 1;
                if (INCREQ && !(SEQV && m_streak == MAXINC)) begin
                    m_kind    = INCSGN ? K_MINC : K_PINC;
                    m_incack  = 1;
                    m_streak  = (m_streak < MAXINC) ? m_streak + 1 : MAXINC;
                end else if (SEQV) begin
                    m_kind   = int'(SEQ);
                    m_seqack = 1;
                    m_streak = 0;
                end else begin
                    m_kind   = K_NOOP;
                    m_streak = 0;
                end
            end else begin
                m_tp = m_tp + 1;
            end
        end
    end

    always @(negedge CLOCK) begin
        if (checking) begin
            checkOutput("tp",     int'(TP),     m_tp);
            checkOutput("t12_",   int'(T12_),   (m_tp == NTP) ? 0 : 1);
            checkOutput("seqack", int'(SEQACK), int'(m_seqack));
            checkOutput("incack", int'(INCACK), int'(m_incack));
            checkOutput("busy",   int'(BUSY),   (m_kind != K_NOOP) ? 1 : 0);
            checkOutput("gates",  int'(observed_gates()), int'(expected_gates(m_kind, m_tp)));
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyStimulus(0, 0, 0, 0, 0);
        #1 rst_ = 1'b0;
        #2;
        checkOutput("reset_tp",    int'(TP), 1);
        checkOutput("reset_t12_",  int'(T12_), 1);
        checkOutput("reset_acks",  int'({SEQACK, INCACK, BUSY}), 0);
        checkOutput("reset_gates", int'(observed_gates()), 0);
        repeat (2) @(negedge CLOCK);
        rst_     = 1'b1;
        checking = 1'b1;

        repeat (36) @(negedge CLOCK);
        wait_tp(12);
        checkOutput("idle_t12_low", int'(T12_), 0);

        // AD subsequence
        wait_tp(11);
        applyStimulus(0, 1, 3, 0, 0);
        wait_tp(1);
        checkOutput("ad_seqack", int'(SEQACK), 1);
        checkOutput("ad_busy", int'(BUSY), 1);
        applyStimulus(0, 0, 0, 0, 0);
        wait_tp(7);
        checkOutput("ad_t7_rg_wb", int'({RG_, WB_}), 0);
        wait_tp(8);
        checkOutput("ad_t8_rb_wy_a2x", int'({RB_, WY_, A2X_}), 0);
        wait_tp(10);
        checkOutput("ad_t10_ru_wa", int'({RU_, WA_}), 0);

        // increments against a pending CA: three INC MCTs then CA
        wait_tp(11);
        applyStimulus(0, 1, 1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            wait_tp(1);
            checkOutput("streak_incack", int'(INCACK), 1);
            checkOutput("streak_no_seqack", int'(SEQACK), 0);
            wait_tp(5);
            checkOutput("pinc_ci", int'(CI), 1);
        end
        wait_tp(1);
        checkOutput("ca_seqack", int'(SEQACK), 1);
        checkOutput("ca_no_incack", int'(INCACK), 0);
        applyStimulus(0, 0, 0, 0, 0);
        wait_tp(7);
        checkOutput("ca_t7_rg", int'(RG_), 0);

        // MINC
        wait_tp(11);
        applyStimulus(0, 0, 0, 1, 1);
        wait_tp(1);
        checkOutput("minc_incack", int'(INCACK), 1);
        applyStimulus(0, 0, 0, 0, 0);
        wait_tp(5);
        checkOutput("minc_monex", int'(MONEX_), 0);
        checkOutput("minc_no_ci", int'(CI), 0);
        wait_tp(7);
        checkOutput("minc_ru_wg", int'({RU_, WG_}), 0);

        // GOJAM in the middle of an AD MCT
        wait_tp(11);
        applyStimulus(0, 1, 3, 0, 0);
        wait_tp(1);
        applyStimulus(0, 0, 0, 0, 0);
        wait_tp(8);
        applyStimulus(1, 0, 0, 0, 0);
        @(negedge CLOCK);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("gojam_tp1", int'(TP), 1);
        checkOutput("gojam_busy", int'(BUSY), 0);
        repeat (12) begin
            @(negedge CLOCK);
            checkOutput("gojam_no_ru_wa", int'({RU_, WA_}), 3);
        end

        // held GOJAM at TP==NTP beats arbitration, requests stay pending
        wait_tp(12);
        applyStimulus(1, 1, 2, 1, 0);
        @(negedge CLOCK);
        checkOutput("gojam_noack", int'({SEQACK, INCACK}), 0);
        repeat (2) begin
            @(negedge CLOCK);
            checkOutput("gojam_hold_tp", int'(TP), 1);
        end
        applyStimulus(0, 1, 2, 1, 0);
        wait_tp(1);
        checkOutput("after_gojam_incack", int'(INCACK), 1);
        applyStimulus(0, 1, 2, 0, 0);
        wait_tp(1);
        checkOutput("ts_seqack", int'(SEQACK), 1);
        applyStimulus(0, 0, 0, 0, 0);

        // async reset at TP5 of the TS MCT
        wait_tp(5);
        checkOutput("ts_t5_ra_wg", int'({RA_, WG_}), 0);
        #2 rst_ = 1'b0;
        #1;
        checkOutput("rst_mid_ra_wg", int'({RA_, WG_}), 3);
        checkOutput("rst_mid_tp", int'(TP), 1);
        checkOutput("rst_mid_busy", int'(BUSY), 0);
        @(negedge CLOCK);
        rst_ = 1'b1;
        repeat (26) @(negedge CLOCK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
